alu: RTL and testbench

//  Registered MIPS-subset execute-stage ALU. Decodes a 32-bit instruction word,

---
 rtl/alu.sv | 184 ++++++++++++++++++
 tb/tb_alu.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// Registered MIPS-subset execute-stage ALU.
// Decodes one instruction per cycle, operates on gr1 (rs) / gr2 (rt) or the
// immediate, and registers the result, the {zero, overflow, negative} flags
// and the HI/LO pair on the rising clock edge. There is no handshake: every
// cycle is one instruction and outputs are valid one edge after the inputs.
module alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_datain,
  input  logic [31:0] gr1,
  input  logic [31:0] gr2,
  output logic [31:0] c,
  output logic [2:0]  zon,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // Instruction fields
  logic [5:0]  opcode;
  logic [5:0]  func;
  logic [4:0]  shamt;
  logic [15:0] imm;

  // Operands (combinational) and architectural registers
  logic [31:0] reg_A;
  logic [31:0] reg_B;
  logic [31:0] reg_C;
  logic [31:0] reg_hi;
  logic [31:0] reg_lo;
  logic [2:0]  reg_zon;

  // Next-state values
  logic [31:0] c_next;
  logic [31:0] hi_next;
  logic [31:0] lo_next;
  logic        ov_next;

  // Shared arithmetic
  logic [31:0] sum;
  logic [31:0] diff;
  logic        add_ov;
  logic        sub_ov;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] div_b;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] udq;
  logic [31:0] udr;
  logic [31:0] sq;
  logic [31:0] sr;

  // Register-number fields are decoded upstream; only the operand values arrive here.
  logic        unused_fields;
  assign unused_fields = ^i_datain[25:16];

  assign opcode = i_datain[31:26];
  assign func   = i_datain[5:0];
  assign shamt  = i_datain[10:6];
  assign imm    = i_datain[15:0];

  // Operand selection: R-type and branches use rt, logical immediates zero-extend, others sign-extend
  always_comb begin
    reg_A = gr1;
    reg_B = {{16{imm[15]}}, imm};
    case (opcode)
      6'h00, 6'h04, 6'h05: reg_B = gr2;
      6'h0C, 6'h0D, 6'h0E: reg_B = {16'd0, imm};
      default:             reg_B = {{16{imm[15]}}, imm};
    endcase
  end

  // Adder/subtractor with signed overflow detection
  always_comb begin
    sum    = reg_A + reg_B;
    diff   = reg_A - reg_B;
    add_ov = (reg_A[31] == reg_B[31]) && (sum[31] != reg_A[31]);
    sub_ov = (reg_A[31] != reg_B[31]) && (diff[31] != reg_A[31]);
  end

  // Multipliers: sign- or zero-extend to 64 bits and keep the low 64 product bits
  always_comb begin
    prod_s = {{32{reg_A[31]}}, reg_A} * {{32{reg_B[31]}}, reg_B};
    prod_u = {32'd0, reg_A} * {32'd0, reg_B};
  end

  // Dividers: signed divide done on magnitudes so -2^31 / -1 wraps to 0x80000000 rem 0;
  // divisor forced to 1 on zero so the datapath never sees x/0 (result overridden later)
  always_comb begin
    div_b = (reg_B == 32'd0) ? 32'd1 : reg_B;
    abs_a = reg_A[31] ? (32'd0 - reg_A) : reg_A;
    abs_b = div_b[31] ? (32'd0 - div_b) : div_b;
    uq    = abs_a / abs_b;
    ur    = abs_a % abs_b;
    sq    = (reg_A[31] ^ div_b[31]) ? (32'd0 - uq) : uq;
    sr    = reg_A[31] ? (32'd0 - ur) : ur;
    udq   = reg_A / div_b;
    udr   = reg_A % div_b;
  end

  // Instruction decode and result select; mult/div and unsupported encodings leave c=0
  always_comb begin
    c_next  = 32'd0;
    ov_next = 1'b0;
    hi_next = reg_hi;
    lo_next = reg_lo;
    case (opcode)
      6'h00: begin
        case (func)
          6'h20: begin c_next = sum;  ov_next = add_ov; end
          6'h21: c_next = sum;
          6'h22: begin c_next = diff; ov_next = sub_ov; end
          6'h23: c_next = diff;
          6'h24: c_next = reg_A & reg_B;
          6'h25: c_next = reg_A | reg_B;
          6'h26: c_next = reg_A ^ reg_B;
          6'h27: c_next = ~(reg_A | reg_B);
          6'h2A: c_next = {31'd0, $signed(reg_A) < $signed(reg_B)};
          6'h2B: c_next = {31'd0, reg_A < reg_B};
          6'h18: begin hi_next = prod_s[63:32]; lo_next = prod_s[31:0]; end
          6'h19: begin hi_next = prod_u[63:32]; lo_next = prod_u[31:0]; end
          6'h1A: begin
            if (reg_B == 32'd0) begin
              hi_next = reg_A;
              lo_next = 32'hFFFF_FFFF;
            end else begin
              hi_next = sr;
              lo_next = sq;
            end
          end
          6'h1B: begin
            if (reg_B == 32'd0) begin
              hi_next = reg_A;
              lo_next = 32'hFFFF_FFFF;
            end else begin
              hi_next = udr;
              lo_next = udq;
            end
          end
          6'h00: c_next = reg_B << shamt;
          6'h02: c_next = reg_B >> shamt;
          6'h03: c_next = $signed(reg_B) >>> shamt;
          6'h04: c_next = reg_B << reg_A[4:0];
          6'h06: c_next = reg_B >> reg_A[4:0];
          6'h07: c_next = $signed(reg_B) >>> reg_A[4:0];
          default: c_next = 32'd0;
        endcase
      end
      6'h08: begin c_next = sum; ov_next = add_ov; end
      6'h09: c_next = sum;
      6'h0A: c_next = {31'd0, $signed(reg_A) < $signed(reg_B)};
      6'h0B: c_next = {31'd0, reg_A < reg_B};
      6'h0C: c_next = reg_A & reg_B;
      6'h0D: c_next = reg_A | reg_B;
      6'h0E: c_next = reg_A ^ reg_B;
      6'h23, 6'h2B: c_next = sum;
      6'h04, 6'h05: c_next = diff;
      default: c_next = 32'd0;
    endcase
  end

  // Result, flag and HI/LO registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_C   <= 32'd0;
      reg_zon <= 3'd0;
      reg_hi  <= 32'd0;
      reg_lo  <= 32'd0;
    end else begin
      reg_C   <= c_next;
      reg_zon <= {c_next == 32'd0, ov_next, c_next[31]};
      reg_hi  <= hi_next;
      reg_lo  <= lo_next;
    end
  end

  assign c   = reg_C;
  assign zon = reg_zon;
  assign hi  = reg_hi;
  assign lo  = reg_lo;

endmodule

// File: tb/tb_alu.sv
// Testbench for alu: directed cases from the datasheet examples, a mid-stream
// asynchronous reset, then randomized instructions against a reference model
// that evaluates each instruction with wide integer arithmetic.
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] i_datain;
  logic [31:0] gr1;
  logic [31:0] gr2;
  logic [31:0] c;
  logic [2:0]  zon;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0] m_c;
  logic [2:0]  m_zon;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  alu dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_datain (i_datain),
    .gr1      (gr1),
    .gr2      (gr2),
    .c        (c),
    .zon      (zon),
    .hi       (hi),
    .lo       (lo)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_r(input logic [5:0] fn, input logic [4:0] sh);
    logic [14:0] regs;
    regs = 15'($urandom);
    return {6'h00, regs, sh, fn};
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [15:0] im);
    logic [9:0] regs;
    regs = 10'($urandom);
    return {op, regs, im};
  endfunction

  // Reference model: each instruction evaluated with 64-bit integer arithmetic
  task automatic model_step(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    logic [5:0]  op;
    logic [5:0]  fn;
    int unsigned sh;
    int          sa, sb, simm, t;
    shortint     si;
    longint      la, lb, r;
    longint unsigned ua, ub, up;
    logic [31:0] uimm, zimm, res;
    logic        ov, fixed;
    op = ins[31:26];
    fn = ins[5:0];
    sh = ins[10:6];
    sa = a; sb = b; la = sa; lb = sb; ua = a; ub = b;
    si = ins[15:0]; simm = si; uimm = simm; zimm = {16'd0, ins[15:0]};
    res = 32'd0; ov = 1'b0; fixed = 1'b0;
    if (op == 6'h00) begin
      case (fn)
        6'h20: begin r = la + lb; res = r[31:0]; t = res; ov = (r != t); end
        6'h21: res = a + b;
        6'h22: begin r = la - lb; res = r[31:0]; t = res; ov = (r != t); end
        6'h23: res = a - b;
        6'h24: res = a & b;
        6'h25: res = a | b;
        6'h26: res = a ^ b;
        6'h27: res = ~(a | b);
        6'h2A: res = (sa < sb) ? 32'd1 : 32'd0;
        6'h2B: res = (a < b) ? 32'd1 : 32'd0;
        6'h18: begin r = la * lb; m_hi = r[63:32]; m_lo = r[31:0]; fixed = 1'b1; end
        6'h19: begin up = ua * ub; m_hi = up[63:32]; m_lo = up[31:0]; fixed = 1'b1; end
        6'h1A: begin
          fixed = 1'b1;
          if (b == 32'd0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; end
          else begin r = la / lb; m_lo = r[31:0]; r = la % lb; m_hi = r[31:0]; end
        end
        6'h1B: begin
          fixed = 1'b1;
          if (b == 32'd0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; end
          else begin m_lo = a / b; m_hi = a % b; end
        end
        6'h00: res = b << sh;
        6'h02: res = b >> sh;
        6'h03: begin t = sb >>> sh; res = t; end
        6'h04: res = b << a[4:0];
        6'h06: res = b >> a[4:0];
        6'h07: begin t = sb >>> a[4:0]; res = t; end
        default: fixed = 1'b1;
      endcase
    end else begin
      case (op)
        6'h08: begin r = la + simm; res = r[31:0]; t = res; ov = (r != t); end
        6'h09: res = a + uimm;
        6'h0A: res = (sa < simm) ? 32'd1 : 32'd0;
        6'h0B: res = (a < uimm) ? 32'd1 : 32'd0;
        6'h0C: res = a & zimm;
        6'h0D: res = a | zimm;
        6'h0E: res = a ^ zimm;
        6'h23, 6'h2B: res = a + uimm;
        6'h04, 6'h05: res = a - b;
        default: fixed = 1'b1;
      endcase
    end
    if (fixed) begin
      m_c = 32'd0;
      m_zon = 3'b100;
    end else begin
      m_c = res;
      m_zon = {res == 32'd0, ov, res[31]};
    end
  endtask

  // Drive one instruction (called between a falling and the next rising edge),
  // then compare all outputs just after the rising edge and move to the next falling edge.
  task automatic run_op(input string tag, input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    i_datain = ins;
    gr1 = a;
    gr2 = b;
    model_step(ins, a, b);
    @(posedge clk);
    #1;
    check({tag, "_c"},   c,            m_c);
    check({tag, "_zon"}, {29'd0, zon}, {29'd0, m_zon});
    check({tag, "_hi"},  hi,           m_hi);
    check({tag, "_lo"},  lo,           m_lo);
    @(negedge clk);
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] corners [6];
    corners = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0011};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  // Main sequence
  initial begin
    logic [5:0] r_funcs [20];
    logic [5:0] i_ops [13];
    logic [31:0] ins;
    r_funcs = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
                6'h18, 6'h19, 6'h1A, 6'h1B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
    i_ops   = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B,
                6'h04, 6'h05, 6'h3F, 6'h11};
    rst_n = 1'b0;
    i_datain = 32'd0;
    gr1 = 32'd0;
    gr2 = 32'd0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_c",   c,            32'd0);
    check("rst_zon", {29'd0, zon}, 32'd0);
    check("rst_hi",  hi,           32'd0);
    check("rst_lo",  lo,           32'd0);
    rst_n = 1'b1;

    // Directed datasheet cases, with explicit constant expectations alongside the model
    run_op("add", mk_r(6'h20, 5'd0), 32'h4040_4040, 32'hDDDD_DDDD);
    check("add_const", c, 32'h1E1E_1E1D);
    run_op("addi", mk_i(6'h08, 16'hFFFF), 32'h7FFF_FFFF, 32'h0);
    check("addi_const", c, 32'h7FFF_FFFE);
    run_op("sub_eq", mk_r(6'h22, 5'd0), 32'h5DDD_DDDD, 32'h5DDD_DDDD);
    check("sub_eq_zon", {29'd0, zon}, 32'd4);
    run_op("add_ovf", mk_r(6'h20, 5'd0), 32'h7FFF_FFFF, 32'h0000_0001);
    check("add_ovf_zon", {29'd0, zon}, 32'd3);
    run_op("mult", mk_r(6'h18, 5'd0), 32'hFFFF_FFFF, 32'h0000_0001);
    check("mult_hi_const", hi, 32'hFFFF_FFFF);
    run_op("div", mk_r(6'h1A, 5'd0), 32'hFFFF_FFE1, 32'h0000_0011);
    check("div_hi_const", hi, 32'hFFFF_FFF2);
    run_op("addu_hold", mk_r(6'h21, 5'd0), 32'h1234_5678, 32'h1);
    run_op("slt", mk_r(6'h2A, 5'd0), 32'h4040_4040, 32'hDDDD_DDDD);
    run_op("sltu", mk_r(6'h2B, 5'd0), 32'h4040_4040, 32'hDDDD_DDDD);
    check("sltu_const", c, 32'd1);
    run_op("andi", mk_i(6'h0C, 16'h0011), 32'hFFFF_FFE1, 32'h0);
    check("andi_const", c, 32'd1);
    run_op("sll", mk_r(6'h00, 5'd1), 32'h0, 32'hDDDD_DDDD);
    check("sll_const", c, 32'hBBBB_BBBA);
    run_op("srl", mk_r(6'h02, 5'd1), 32'h0, 32'hDDDD_DDDD);
    check("srl_const", c, 32'h6EEE_EEEE);
    run_op("sra", mk_r(6'h03, 5'd1), 32'h0, 32'hDDDD_DDDD);
    check("sra_const", c, 32'hEEEE_EEEE);
    run_op("sllv", mk_r(6'h04, 5'd0), 32'h2, 32'hDDDD_DDDD);
    check("sllv_const", c, 32'h7777_7774);
    run_op("divz", mk_r(6'h1B, 5'd0), 32'hCAFE_F00D, 32'h0);
    check("divz_lo_const", lo, 32'hFFFF_FFFF);
    run_op("div_min", mk_r(6'h1A, 5'd0), 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("beq", mk_i(6'h04, 16'h0010), 32'h55, 32'h55);
    run_op("bne", mk_i(6'h05, 16'h0010), 32'h55, 32'h56);
    run_op("bad_func", mk_r(6'h3F, 5'd0), 32'h5, 32'h6);
    run_op("bad_op", mk_i(6'h3F, 16'h1234), 32'h5, 32'h6);

    // Asynchronous reset mid-stream: outputs clear with no clock edge
    run_op("pre_rst", mk_r(6'h19, 5'd0), 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    #1 rst_n = 1'b0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    #1;
    check("arst_c",   c,            32'd0);
    check("arst_zon", {29'd0, zon}, 32'd0);
    check("arst_hi",  hi,           32'd0);
    check("arst_lo",  lo,           32'd0);
    #1 rst_n = 1'b1;
    run_op("post_rst", mk_r(6'h18, 5'd0), 32'h0001_0000, 32'h0001_0000);
    check("post_rst_hi_const", hi, 32'h0000_0001);

    // Randomized instruction stream
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        ins = $urandom;
      end else if ($urandom_range(0, 1) == 0) begin
        ins = mk_r(r_funcs[$urandom_range(0, 19)], 5'($urandom));
      end else begin
        ins = mk_i(i_ops[$urandom_range(0, 12)], 16'($urandom));
      end
      run_op($sformatf("rnd%0d_%h", i, ins), ins, pick_operand(), pick_operand());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
